// File: rtl/mix_columns_serial_if.sv
// mix_columns_serial_if: input/output handshake bundle for mix_columns_serial.
// in_inv only exists when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_serial_if;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
`ifdef MIX_COLUMNS_INV_EN
  logic         in_inv;
`endif
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  modport slave (
`ifdef MIX_COLUMNS_INV_EN
    input  in_inv,
`endif
    input  in_data, in_valid, in_bypass, out_ready,
    output in_ready, out_data, out_valid
  );
  modport master (
`ifdef MIX_COLUMNS_INV_EN
    output in_inv,
`endif
    output in_data, in_valid, in_bypass, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mix_columns_serial.sv
// mix_columns_serial: AES MixColumns, one column per cycle, with final-round bypass.
// Define MIX_COLUMNS_INV_EN to add the in_inv port and InvMixColumns.
module mix_columns_serial (
  input logic clk,
  input logic reset,
  mix_columns_serial_if.slave io
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]   r_state, r_cnt;
  logic [127:0] r_data, r_out;
  logic [31:0]  w_col, w_mix;
  logic [6:0]   w_base;
`ifdef MIX_COLUMNS_INV_EN
  logic         r_inv;
`endif
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rf(input logic [7:0] p, q, r, s);
    return xt(p) ^ xt(q) ^ q ^ r ^ s;
  endfunction
  function automatic logic [31:0] col_fwd(input logic [31:0] c);
    return {rf(c[31:24], c[23:16], c[15:8], c[7:0]), rf(c[23:16], c[15:8], c[7:0], c[31:24]),
            rf(c[15:8], c[7:0], c[31:24], c[23:16]), rf(c[7:0], c[31:24], c[23:16], c[15:8])};
  endfunction
`ifdef MIX_COLUMNS_INV_EN
  // Multiply by a 4-bit constant as a sum of a, 2a, 4a, 8a.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h0) ^ (k[1] ? x2 : 8'h0) ^ (k[2] ? x4 : 8'h0) ^ (k[3] ? x8 : 8'h0);
  endfunction
  function automatic logic [7:0] ri(input logic [7:0] p, q, r, s);
    return gm(p, 4'he) ^ gm(q, 4'hb) ^ gm(r, 4'hd) ^ gm(s, 4'h9);
  endfunction
  function automatic logic [31:0] col_inv(input logic [31:0] c);
    return {ri(c[31:24], c[23:16], c[15:8], c[7:0]), ri(c[23:16], c[15:8], c[7:0], c[31:24]),
            ri(c[15:8], c[7:0], c[31:24], c[23:16]), ri(c[7:0], c[31:24], c[23:16], c[15:8])};
  endfunction
`endif
  assign io.in_ready  = r_state == IDLE;
  assign io.out_valid = r_state == DONE;
  assign io.out_data  = r_out;
  // Column c sits at bit offset 32*(3-c), i.e. {~c, 5'b0}.
  assign w_base = {~r_cnt, 5'd0};
  always_comb begin
    w_col = r_data[w_base +: 32];
`ifdef MIX_COLUMNS_INV_EN
    w_mix = r_inv ? col_inv(w_col) : col_fwd(w_col);
`else
    w_mix = col_fwd(w_col);
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_data  <= 128'h0;
      r_out   <= 128'h0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (io.in_valid) begin
          r_data  <= io.in_data;
          r_cnt   <= 2'd0;
          r_state <= io.in_bypass ? DONE : BUSY;
          if (io.in_bypass) r_out <= io.in_data;
`ifdef MIX_COLUMNS_INV_EN
          r_inv   <= io.in_inv;
`endif
        end
        BUSY: begin
          r_out[w_base +: 32] <= w_mix;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= DONE;
        end
        DONE: if (io.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_serial.sv
// tb_mix_columns_serial: directed vectors for mix_columns_serial; checks data, latency, backpressure, reset abort.
module tb_mix_columns_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  mix_columns_serial_if mc_if ();
  mix_columns_serial dut (.clk(clk), .reset(reset), .io(mc_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [127:0] d, input logic byp, input logic [127:0] exp, input int elat, input int hold);
    int lat;
    chk("idle_ready", 128'(mc_if.in_ready), 128'd1);
    mc_if.in_data   = d;
    mc_if.in_bypass = byp;
    mc_if.in_valid  = 1'b1;
    mc_if.out_ready = hold == 0;
    step();
    mc_if.in_valid = 1'b0;
    mc_if.in_data  = ~d;
    lat = 0;
    while (!mc_if.out_valid && lat < 20) begin
      chk("busy_ready", 128'(mc_if.in_ready), 128'd0);
      step();
      lat++;
    end
    chk("latency", 128'(lat), 128'(elat));
    chk("data", mc_if.out_data, exp);
    repeat (hold) begin
      step();
      chk("hold_data", mc_if.out_data, exp);
      chk("hold_ready", 128'(mc_if.in_ready), 128'd0);
    end
    mc_if.out_ready = 1'b1;
    step();
    chk("ready_back", 128'(mc_if.in_ready), 128'd1);
    chk("valid_drop", 128'(mc_if.out_valid), 128'd0);
  endtask
  initial begin
    mc_if.in_data   = '0;
    mc_if.in_valid  = 1'b0;
    mc_if.in_bypass = 1'b0;
    mc_if.out_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    mc_if.in_inv    = 1'b0;
`endif
    repeat (2) step();
    reset = 1'b0;
    chk("rst_ready", 128'(mc_if.in_ready), 128'd1);
    chk("rst_valid", 128'(mc_if.out_valid), 128'd0);
    chk("rst_data", mc_if.out_data, 128'h0);
    run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4, 0);
    run(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, 4, 0);
    run(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff, 0, 0);
    run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4, 10);
    run(128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff, 0, 3);
    mc_if.in_data   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    mc_if.in_bypass = 1'b0;
    mc_if.in_valid  = 1'b1;
    step();
    mc_if.in_valid = 1'b0;
    repeat (2) step();
    chk("abort_busy", 128'(mc_if.in_ready), 128'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_data", mc_if.out_data, 128'h0);
    chk("abort_ready", 128'(mc_if.in_ready), 128'd1);
    repeat (6) begin
      step();
      chk("abort_valid", 128'(mc_if.out_valid), 128'd0);
    end
    run(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c, 4, 0);
`ifdef MIX_COLUMNS_INV_EN
    mc_if.in_inv = 1'b1;
    run(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 4, 0);
    mc_if.in_inv = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
